// File: rtl/spi_master_ctrl_if.sv
// Command/response handshake bundle for spi_master_ctrl.
// The host drives commands and receives captured read bytes.
interface spi_master_ctrl_if;
  logic       cmd_valid;
  logic       cmd_ready;
  logic [1:0] cmd_type;
  logic [7:0] cmd_data;
  logic       rsp_valid;
  logic [7:0] rsp_data;
  logic       busy;

  modport master (
    output cmd_valid, cmd_type, cmd_data,
    input  cmd_ready, rsp_valid, rsp_data, busy
  );

  modport slave (
    input  cmd_valid, cmd_type, cmd_data,
    output cmd_ready, rsp_valid, rsp_data, busy
  );
endinterface

// File: rtl/spi_master_ctrl.sv
// SPI master: serialises 11-bit command frames on MOSI under SS_n
// and captures one MISO byte for read-data commands.
module spi_master_ctrl #(
  parameter int RD_WAIT  = 4,
  parameter int WR_HOLD  = 1,
  parameter int IDLE_GAP = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  spi_master_ctrl_if.slave bus,
  output logic             SS_n,
  output logic             MOSI,
  input  logic             MISO
);

  typedef enum logic [2:0] {
    IDLE, START, SHIFT, HOLD, WAIT, CAPTURE, GAP
  } state_t;

  localparam logic [7:0] WAIT_LAST = 8'(RD_WAIT - 1);
  localparam logic [7:0] HOLD_LAST = 8'(WR_HOLD - 1);
  localparam logic [7:0] GAP_LAST  = 8'(IDLE_GAP - 1);

  state_t      state, state_n;
  state_t      after_shift, after_frame;
  logic [7:0]  cnt, cnt_n;
  logic [10:0] frame, frame_n;
  logic        rd, rd_n;
  logic [7:0]  sh, sh_n;
  logic [7:0]  rsp_d, rsp_d_n;
  logic        rsp_v, rsp_v_n;
  logic        ss_n_n, mosi_n;

  // zero-length phases are skipped entirely
  always_comb begin
    after_frame = (IDLE_GAP > 0) ? GAP : IDLE;
    if (rd)
      after_shift = (RD_WAIT > 0) ? WAIT : CAPTURE;
    else
      after_shift = (WR_HOLD > 0) ? HOLD : after_frame;
  end

  always_comb begin
    state_n = state;
    cnt_n   = cnt;
    frame_n = frame;
    rd_n    = rd;
    sh_n    = sh;
    rsp_d_n = rsp_d;
    rsp_v_n = 1'b0;
    mosi_n  = 1'b0;
    unique case (state)
      IDLE: begin
        if (bus.cmd_valid) begin
          state_n = START;
          frame_n = {bus.cmd_type[1], bus.cmd_type, bus.cmd_data};
          rd_n    = &bus.cmd_type;
          cnt_n   = 8'd0;
        end
      end
      START: begin
        state_n = SHIFT;
        cnt_n   = 8'd0;
        mosi_n  = frame[10];
        frame_n = {frame[9:0], 1'b0};
      end
      SHIFT: begin
        if (cnt == 8'd10) begin
          state_n = after_shift;
          cnt_n   = 8'd0;
        end else begin
          cnt_n   = cnt + 8'd1;
          mosi_n  = frame[10];
          frame_n = {frame[9:0], 1'b0};
        end
      end
      HOLD: begin
        if (cnt == HOLD_LAST) begin
          state_n = after_frame;
          cnt_n   = 8'd0;
        end else begin
          cnt_n = cnt + 8'd1;
        end
      end
      WAIT: begin
        if (cnt == WAIT_LAST) begin
          state_n = CAPTURE;
          cnt_n   = 8'd0;
        end else begin
          cnt_n = cnt + 8'd1;
        end
      end
      CAPTURE: begin
        sh_n = {sh[6:0], MISO};
        if (cnt == 8'd7) begin
          state_n = after_frame;
          cnt_n   = 8'd0;
          rsp_v_n = 1'b1;
          rsp_d_n = {sh[6:0], MISO};
        end else begin
          cnt_n = cnt + 8'd1;
        end
      end
      GAP: begin
        if (cnt == GAP_LAST) begin
          state_n = IDLE;
          cnt_n   = 8'd0;
        end else begin
          cnt_n = cnt + 8'd1;
        end
      end
      default: begin
        state_n = IDLE;
        cnt_n   = 8'd0;
      end
    endcase
    ss_n_n = (state_n == IDLE) || (state_n == GAP);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state <= IDLE;
      cnt   <= 8'd0;
      frame <= 11'd0;
      rd    <= 1'b0;
      sh    <= 8'd0;
      rsp_d <= 8'd0;
      rsp_v <= 1'b0;
      SS_n  <= 1'b1;
      MOSI  <= 1'b0;
    end else begin
      state <= state_n;
      cnt   <= cnt_n;
      frame <= frame_n;
      rd    <= rd_n;
      sh    <= sh_n;
      rsp_d <= rsp_d_n;
      rsp_v <= rsp_v_n;
      SS_n  <= ss_n_n;
      MOSI  <= mosi_n;
    end
  end

  assign bus.cmd_ready = (state == IDLE);
  assign bus.busy      = (state != IDLE);
  assign bus.rsp_valid = rsp_v;
  assign bus.rsp_data  = rsp_d;

endmodule

// File: tb/tb_spi_master_ctrl.sv
// Randomised bench for spi_master_ctrl: default build and a
// RD_WAIT=2/IDLE_GAP=0 build, each checked against a frame-level model.
module tb_spi_master_ctrl;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       cmd_valid;
  logic [1:0] cmd_type;
  logic [7:0] cmd_data;
  logic       miso;
  bit         sel;
  logic       ss1, mosi1, ss2, mosi2;

  logic       o_ss, o_mosi, o_rv, o_rdy, o_busy;
  logic [7:0] o_rsp;

  int checks = 0;
  int errors = 0;
  logic [7:0] exp_rsp [2];

  always #5 clk = ~clk;

  spi_master_ctrl_if bus1 ();
  spi_master_ctrl_if bus2 ();

  assign bus1.cmd_valid = cmd_valid & ~sel;
  assign bus1.cmd_type  = cmd_type;
  assign bus1.cmd_data  = cmd_data;
  assign bus2.cmd_valid = cmd_valid & sel;
  assign bus2.cmd_type  = cmd_type;
  assign bus2.cmd_data  = cmd_data;

  spi_master_ctrl dut1 (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus1.slave),
    .SS_n  (ss1),
    .MOSI  (mosi1),
    .MISO  (miso)
  );

  spi_master_ctrl #(
    .RD_WAIT  (2),
    .WR_HOLD  (1),
    .IDLE_GAP (0)
  ) dut2 (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus2.slave),
    .SS_n  (ss2),
    .MOSI  (mosi2),
    .MISO  (miso)
  );

  assign o_ss   = sel ? ss2 : ss1;
  assign o_mosi = sel ? mosi2 : mosi1;
  assign o_rv   = sel ? bus2.rsp_valid : bus1.rsp_valid;
  assign o_rsp  = sel ? bus2.rsp_data : bus1.rsp_data;
  assign o_rdy  = sel ? bus2.cmd_ready : bus1.cmd_ready;
  assign o_busy = sel ? bus2.busy : bus1.busy;

  task automatic check(input string tag, input logic [7:0] got,
                       input logic [7:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Expected frame: START, 11 MSB-first bits, then HOLD or WAIT+8
  // capture cycles, then the SS_n-high gap before ready returns.
  task automatic run_cmd(input logic [1:0] t, input logic [7:0] d,
                         input logic [7:0] mb, input bit hold,
                         input bit inject, input int rst_at);
    int          rw   = sel ? 2 : 4;
    int          ig   = sel ? 0 : 1;
    int          wh   = 1;
    logic [10:0] f    = {t[1], t, d};
    bit          rd   = (t == 2'b11);
    int          low  = rd ? 20 + rw : 12 + wh;
    int          last = low + ig;
    int          n    = 0;
    while (!o_rdy && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (!o_rdy) begin
      check("ready_timeout", 8'd0, 8'd1);
      return;
    end
    cmd_valid = 1'b1;
    cmd_type  = t;
    cmd_data  = d;
    for (int i = 0; i <= last; i++) begin
      int         c;
      logic       e_ss, e_mosi, e_rv, e_rdy;
      logic [7:0] e_rsp;
      @(negedge clk);
      if (rst_at >= 0 && i == rst_at + 1) begin
        check("rst_ss", 8'(o_ss), 8'd1);
        check("rst_mosi", 8'(o_mosi), 8'd0);
        check("rst_rv", 8'(o_rv), 8'd0);
        check("rst_rsp", o_rsp, 8'd0);
        check("rst_rdy", 8'(o_rdy), 8'd1);
        rst_n      = 1'b1;
        exp_rsp[0] = 8'd0;
        exp_rsp[1] = 8'd0;
        return;
      end
      e_ss   = (i >= low);
      e_mosi = (i >= 1 && i <= 11) ? f[11-i] : 1'b0;
      e_rv   = rd && (i == low);
      e_rdy  = (i >= last);
      e_rsp  = (rd && i >= low) ? mb : exp_rsp[sel];
      check($sformatf("ss[%0d]", i), 8'(o_ss), 8'(e_ss));
      check($sformatf("mosi[%0d]", i), 8'(o_mosi), 8'(e_mosi));
      check($sformatf("rv[%0d]", i), 8'(o_rv), 8'(e_rv));
      check($sformatf("rsp[%0d]", i), o_rsp, e_rsp);
      check($sformatf("rdy[%0d]", i), 8'(o_rdy), 8'(e_rdy));
      check($sformatf("busy[%0d]", i), 8'(o_busy), 8'(!e_rdy));
      cmd_valid = hold;
      if (inject && i == 5) begin
        cmd_valid = 1'b1;
        cmd_type  = 2'b11;
        cmd_data  = 8'($urandom);
      end
      if (i == rst_at) rst_n = 1'b0;
      c    = i - (12 + rw);
      miso = (rd && c >= 0 && c < 8) ? mb[7-c] : 1'($urandom_range(0, 1));
    end
    if (rd) exp_rsp[sel] = mb;
  endtask

  initial begin
    rst_n      = 1'b0;
    cmd_valid  = 1'b0;
    cmd_type   = 2'b00;
    cmd_data   = 8'd0;
    miso       = 1'b0;
    sel        = 1'b0;
    exp_rsp[0] = 8'd0;
    exp_rsp[1] = 8'd0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    for (int s = 0; s < 2; s++) begin
      sel = 1'(s);
      #1;
      check("reset_ss", 8'(o_ss), 8'd1);
      check("reset_mosi", 8'(o_mosi), 8'd0);
      check("reset_rv", 8'(o_rv), 8'd0);
      check("reset_rsp", o_rsp, 8'd0);
      check("reset_rdy", 8'(o_rdy), 8'd1);
      check("reset_busy", 8'(o_busy), 8'd0);
    end
    sel = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    run_cmd(2'b00, 8'h2A, 8'h00, 1'b0, 1'b0, -1);
    run_cmd(2'b11, 8'($urandom), 8'hA5, 1'b0, 1'b0, -1);
    run_cmd(2'b01, 8'h55, 8'h00, 1'b1, 1'b0, -1);
    run_cmd(2'b10, 8'h0F, 8'h00, 1'b0, 1'b0, -1);
    run_cmd(2'b10, 8'($urandom), 8'h00, 1'b0, 1'b1, -1);
    run_cmd(2'b11, 8'($urandom), 8'($urandom), 1'b0, 1'b0, 6);
    run_cmd(2'b11, 8'($urandom), 8'($urandom), 1'b0, 1'b0, -1);
    for (int k = 0; k < 20; k++) begin
      run_cmd(2'($urandom_range(0, 3)), 8'($urandom), 8'($urandom),
              (k < 19) ? 1'($urandom_range(0, 1)) : 1'b0,
              1'($urandom_range(0, 1)), -1);
    end

    sel = 1'b1;
    #1;
    run_cmd(2'b11, 8'($urandom), 8'h3C, 1'b0, 1'b0, -1);
    for (int k = 0; k < 10; k++) begin
      run_cmd(2'($urandom_range(0, 3)), 8'($urandom), 8'($urandom),
              (k < 9) ? 1'($urandom_range(0, 1)) : 1'b0,
              1'b0, -1);
    end

    repeat (2) @(negedge clk);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/spi_master_ctrl.md
Name: spi_master_ctrl

Overview:
- Single-clock SPI master that drives the serial side of the existing SPI slave/RAM subsystem.
- Accepts parallel command requests (write address, write data, read address, read data) and serialises each as an 11-bit frame on MOSI under SS_n.
- For read-data commands it captures 8 bits from MISO and returns them on a one-cycle response strobe.
- Sits between the host/test sequencer and the SPI slave; SPI clock equals clk (no divider).

Parameters:
- RD_WAIT, 4, idle cycles (MOSI=0, SS_n low) between the last MOSI bit and the first MISO capture cycle on read-data frames.
- WR_HOLD, 1, cycles SS_n is held low after the last MOSI bit on non-read-data frames (lets the slave raise rx_valid).
- IDLE_GAP, 1, minimum cycles SS_n stays high after any frame before cmd_ready reasserts.

Ports:
- clk  input  1  system clock; all logic on rising edge.
- rst_n  input  1  synchronous active-low reset.
- cmd_valid  input  1  command request.
- cmd_ready  output  1  block can accept a command; high only in IDLE.
- cmd_type  input  2  00 write addr, 01 write data, 10 read addr, 11 read data.
- cmd_data  input  8  address or write data; ignored content for 11 but still shifted.
- rsp_valid  output  1  one-cycle strobe; rsp_data valid.
- rsp_data  output  8  byte captured from MISO, held until next capture.
- busy  output  1  equals !cmd_ready.
- SS_n  output  1  slave select, active low, registered.
- MOSI  output  1  serial data to slave, registered.
- MISO  input  1  serial data from slave.

Behaviour:
- Reset (rst_n=0 at an edge): state IDLE, SS_n=1, MOSI=0, rsp_valid=0, rsp_data=0, cmd_ready=1, all counters 0. Reset mid-frame aborts the frame immediately: SS_n=1 after that edge, no rsp_valid for the aborted command.
- Accept: cmd_valid&&cmd_ready at edge E0 latches frame F[10:0] = {cmd_type[1], cmd_type, cmd_data}. cmd_ready drops after E0. cmd_valid while busy is ignored; nothing is queued.
- States:
  - IDLE: SS_n=1, MOSI=0.
  - START: 1 cycle; SS_n=0, MOSI=0.
  - SHIFT: 11 cycles; MOSI=F[10] down to F[0], one bit per cycle, MSB first.
  - HOLD: WR_HOLD cycles; MOSI=0, SS_n=0. Entered when cmd_type!=11.
  - WAIT: RD_WAIT cycles; MOSI=0, SS_n=0. Entered when cmd_type==11.
  - CAPTURE: 8 cycles; MISO sampled at the edge ending each cycle into a shift register, MSB first.
  - GAP: IDLE_GAP cycles; SS_n=1, MOSI=0.
  - GAP then returns to IDLE.
- State transitions:
  - START→SHIFT.
  - SHIFT→HOLD or WAIT.
  - HOLD→GAP.
  - WAIT→CAPTURE.
  - CAPTURE→GAP.
  - GAP→IDLE.
- Timing from E0 (defaults):
  - Write/read-addr frames: SS_n low for 13 cycles (after E0..E13).
  - Read-data frames: SS_n low for 1+11+RD_WAIT+8 = 24 cycles.
  - Read-data frames: rsp_valid=1 for exactly the cycle after the 8th capture edge (E24), with rsp_data = captured byte. SS_n rises at the same edge.
- cmd_ready reasserts after IDLE_GAP cycles in GAP. Back-to-back commands therefore have ≥IDLE_GAP SS_n-high cycles between frames.
- Parameter values of 0 for RD_WAIT/WR_HOLD/IDLE_GAP skip the corresponding state.
- rsp_data changes only on rsp_valid cycles.

Test Plan:
- Reset, then write-addr cmd_type=00 cmd_data=0x2A → SS_n low 13 cycles. MOSI over SHIFT = 0,0,0,0,0,1,0,1,0,1,0. No rsp_valid. cmd_ready high again 14 cycles after SS_n rises+gap.
- Read-data cmd_type=11; MISO model drives 0xA5 MSB first aligned to CAPTURE → MOSI frame begins 1,1,1. rsp_valid single pulse at E24+ with rsp_data=0xA5. SS_n high same cycle.
- Back-to-back write-data 0x55 then read-addr 0x0F with cmd_valid held high → exactly IDLE_GAP=1 SS_n-high cycle between frames. Second frame MOSI = 1,1,0,0,0,0,0,1,1,1,1.
- cmd_valid pulsed during an active frame with cmd_type=11 → ignored. No second frame, no rsp_valid.
- rst_n low at SHIFT bit 5 of a read-data frame → SS_n=1, MOSI=0 next cycle. No rsp_valid. rsp_data stays 0. Next command proceeds normally.
- RD_WAIT=2, IDLE_GAP=0 build, read-data with MISO=0x3C → SS_n low 22 cycles, rsp_data=0x3C. cmd_ready one cycle after SS_n rises.
